// File: rtl/best_1ofn_busy_pipe_if.sv
// Bus between the per-zone pattern sorters and the best-1-of-N selector:
// per-zone candidate fields in, winning candidate and valid/busy status out.
interface best_1ofn_busy_pipe_if #(
  parameter int NZONE   = 7,
  parameter int MXKEYB  = 5,
  parameter int MXPATB  = 7,
  parameter int MXQLTB  = 6,
  parameter int MXOFFSB = 4,
  parameter int MXBNDB  = 5,
  parameter int MXPATC  = 12,
  parameter int MXKEYBX = 8
);
  logic                      vld_in;
  logic [NZONE*MXPATB-1:0]   pat;
  logic [NZONE*MXKEYB-1:0]   key;
  logic [NZONE*MXOFFSB-1:0]  offs;
  logic [NZONE*MXQLTB-1:0]   qlt;
  logic [NZONE*MXBNDB-1:0]   bend;
  logic [NZONE*MXPATC-1:0]   carry;
  logic [NZONE-1:0]          bsy_ext;

  logic [MXPATB-1:0]         best_pat;
  logic [MXKEYBX-1:0]        best_key;
  logic [MXKEYBX+1:0]        best_subkey;
  logic [MXQLTB-1:0]         best_qlt;
  logic [MXBNDB-1:0]         best_bend;
  logic [MXPATC-1:0]         best_carry;
  logic [2:0]                best_zone;
  logic                      best_vld;
  logic                      best_bsy;

  modport master (
    output vld_in, pat, key, offs, qlt, bend, carry, bsy_ext,
    input  best_pat, best_key, best_subkey, best_qlt, best_bend, best_carry,
           best_zone, best_vld, best_bsy
  );

  modport slave (
    input  vld_in, pat, key, offs, qlt, bend, carry, bsy_ext,
    output best_pat, best_key, best_subkey, best_qlt, best_bend, best_carry,
           best_zone, best_vld, best_bsy
  );
endinterface

// File: rtl/best_1ofn_busy_pipe.sv
// Two-stage best-1-of-N zone selector: S1 registers the zone candidates and busy
// mask, S2 picks the highest sort key, clamps the key arithmetic and arms hold-off.
module best_1ofn_busy_pipe #(
  parameter int NZONE       = 7,
  parameter int MXKEYB      = 5,
  parameter int MXPATB      = 7,
  parameter int MXQLTB      = 6,
  parameter int MXOFFSB     = 4,
  parameter int MXBNDB      = 5,
  parameter int MXPATC      = 12,
  parameter int SORT_ON_QLT = 1,
  parameter int BUSY_WIN    = 4,
  parameter int HOLD_THR    = 1,
  parameter int MXKEYBX     = 8
) (
  input logic                  clock,
  input logic                  reset,
  best_1ofn_busy_pipe_if.slave bus
);
  localparam int SKW  = (SORT_ON_QLT != 0) ? MXQLTB : MXPATB - 1;
  localparam int HW   = (BUSY_WIN > 0) ? $clog2(BUSY_WIN + 1) : 1;
  localparam int RW   = MXKEYBX + 2;
  localparam int KMAX = NZONE * (2 ** MXKEYB) - 1;

  logic                      r_s1_vld;
  logic [NZONE*MXPATB-1:0]   r_s1_pat;
  logic [NZONE*MXKEYB-1:0]   r_s1_key;
  logic [NZONE*MXOFFSB-1:0]  r_s1_offs;
  logic [NZONE*MXQLTB-1:0]   r_s1_qlt;
  logic [NZONE*MXBNDB-1:0]   r_s1_bend;
  logic [NZONE*MXPATC-1:0]   r_s1_carry;
  logic [NZONE-1:0]          r_s1_bsy;

  logic [HW-1:0]             r_hold [NZONE];
  logic [NZONE-1:0]          w_hold_bsy;

  logic [SKW-1:0]            w_sk [NZONE];
  logic                      w_win_found;
  logic [2:0]                w_win_zone;
  logic [SKW-1:0]            w_win_sk;
  logic [MXPATB-1:0]         w_sel_pat;
  logic [MXKEYB-1:0]         w_sel_key;
  logic [MXOFFSB-1:0]        w_sel_offs;
  logic [MXQLTB-1:0]         w_sel_qlt;
  logic [MXBNDB-1:0]         w_sel_bend;
  logic [MXPATC-1:0]         w_sel_carry;

  logic [RW-1:0]             w_full;
  logic [RW-1:0]             w_raw;
  logic [MXKEYBX-1:0]        w_key;
  logic [MXKEYBX+1:0]        w_subkey;
  logic                      w_load;

  logic [MXPATB-1:0]         r_best_pat;
  logic [MXKEYBX-1:0]        r_best_key;
  logic [MXKEYBX+1:0]        r_best_subkey;
  logic [MXQLTB-1:0]         r_best_qlt;
  logic [MXBNDB-1:0]         r_best_bend;
  logic [MXPATC-1:0]         r_best_carry;
  logic [2:0]                r_best_zone;
  logic                      r_best_vld;
  logic                      r_best_bsy;

  always_comb begin
    for (int z = 0; z < NZONE; z++) begin
      w_hold_bsy[z] = (r_hold[z] != '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_vld   <= 1'b0;
      r_s1_pat   <= '0;
      r_s1_key   <= '0;
      r_s1_offs  <= '0;
      r_s1_qlt   <= '0;
      r_s1_bend  <= '0;
      r_s1_carry <= '0;
      r_s1_bsy   <= '0;
    end else begin
      r_s1_vld   <= bus.vld_in;
      r_s1_pat   <= bus.pat;
      r_s1_key   <= bus.key;
      r_s1_offs  <= bus.offs;
      r_s1_qlt   <= bus.qlt;
      r_s1_bend  <= bus.bend;
      r_s1_carry <= bus.carry;
      r_s1_bsy   <= bus.bsy_ext | w_hold_bsy;
    end
  end

  for (genvar gz = 0; gz < NZONE; gz++) begin : g_sk
    if (SORT_ON_QLT != 0) begin : g_qlt
      assign w_sk[gz] = r_s1_qlt[gz*MXQLTB +: MXQLTB];
    end else begin : g_pat
      assign w_sk[gz] = r_s1_pat[gz*MXPATB+1 +: MXPATB-1];
    end
  end

  // Strict greater-than keeps the lowest zone index on ties; key 0 is still a candidate.
  always_comb begin
    w_win_found = 1'b0;
    w_win_zone  = '0;
    w_win_sk    = '0;
    w_sel_pat   = '0;
    w_sel_key   = '0;
    w_sel_offs  = '0;
    w_sel_qlt   = '0;
    w_sel_bend  = '0;
    w_sel_carry = '0;
    for (int z = 0; z < NZONE; z++) begin
      if (!r_s1_bsy[z] && (!w_win_found || (w_sk[z] > w_win_sk))) begin
        w_win_found = 1'b1;
        w_win_zone  = 3'(z);
        w_win_sk    = w_sk[z];
        w_sel_pat   = r_s1_pat[z*MXPATB +: MXPATB];
        w_sel_key   = r_s1_key[z*MXKEYB +: MXKEYB];
        w_sel_offs  = r_s1_offs[z*MXOFFSB +: MXOFFSB];
        w_sel_qlt   = r_s1_qlt[z*MXQLTB +: MXQLTB];
        w_sel_bend  = r_s1_bend[z*MXBNDB +: MXBNDB];
        w_sel_carry = r_s1_carry[z*MXPATC +: MXPATC];
      end
    end
  end

  // Raw key is treated as two's complement; the MSB flags a result below zero.
  always_comb begin
    w_full = (RW'(w_win_zone) << MXKEYB) + RW'(w_sel_key);
    w_raw  = w_full + RW'(w_sel_offs[3:2]) + RW'(w_sel_offs[1] & w_sel_offs[0]) - RW'(2);
    if (w_raw[RW-1]) begin
      w_key    = '0;
      w_subkey = '0;
    end else if (w_raw > RW'(KMAX)) begin
      w_key    = MXKEYBX'(KMAX);
      w_subkey = {MXKEYBX'(KMAX), 2'b11};
    end else begin
      w_key    = w_raw[MXKEYBX-1:0];
      w_subkey = {w_raw[MXKEYBX-1:0], w_sel_offs[1:0] + 2'd1};
    end
  end

  assign w_load = r_s1_vld & w_win_found & (w_win_sk >= SKW'(HOLD_THR));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_best_pat    <= '0;
      r_best_key    <= '0;
      r_best_subkey <= '0;
      r_best_qlt    <= '0;
      r_best_bend   <= '0;
      r_best_carry  <= '0;
      r_best_zone   <= '0;
      r_best_vld    <= 1'b0;
      r_best_bsy    <= 1'b0;
    end else begin
      r_best_pat    <= '0;
      r_best_key    <= '0;
      r_best_subkey <= '0;
      r_best_qlt    <= '0;
      r_best_bend   <= '0;
      r_best_carry  <= '0;
      r_best_zone   <= '0;
      r_best_vld    <= 1'b0;
      r_best_bsy    <= 1'b0;
      if (r_s1_vld && w_win_found) begin
        r_best_pat    <= w_sel_pat;
        r_best_key    <= w_key;
        r_best_subkey <= w_subkey;
        r_best_qlt    <= w_sel_qlt;
        r_best_bend   <= w_sel_bend;
        r_best_carry  <= w_sel_carry;
        r_best_zone   <= w_win_zone;
        r_best_vld    <= 1'b1;
      end else if (r_s1_vld) begin
        r_best_bsy    <= 1'b1;
      end
    end
  end

  // Reload beats decrement, so a zone that keeps winning stays held off.
  if (BUSY_WIN > 0) begin : g_hold
    always_ff @(posedge clock) begin
      for (int z = 0; z < NZONE; z++) begin
        if (reset) begin
          r_hold[z] <= '0;
        end else if (w_load && (w_win_zone == 3'(z))) begin
          r_hold[z] <= HW'(BUSY_WIN);
        end else if (r_hold[z] != '0) begin
          r_hold[z] <= r_hold[z] - HW'(1);
        end
      end
    end
  end else begin : g_nohold
    always_comb begin
      for (int z = 0; z < NZONE; z++) begin
        r_hold[z] = '0;
      end
    end
  end

  assign bus.best_pat    = r_best_pat;
  assign bus.best_key    = r_best_key;
  assign bus.best_subkey = r_best_subkey;
  assign bus.best_qlt    = r_best_qlt;
  assign bus.best_bend   = r_best_bend;
  assign bus.best_carry  = r_best_carry;
  assign bus.best_zone   = r_best_zone;
  assign bus.best_vld    = r_best_vld;
  assign bus.best_bsy    = r_best_bsy;
endmodule
